// File: rtl/cdc_pkg.sv
// Shared types and limits for the four-phase req/ack clock-domain-crossing blocks.
// Imported by the ack synchronizer and the source-side controller.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } cdc_tx_state_t;

    localparam int CDC_SYNC_STAGES_MIN = 2;
    localparam int CDC_SYNC_STAGES_MAX = 6;

endpackage : cdc_pkg

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for a single-bit handshake signal, reset to 0.
// Shared by the source side (ack) and the destination side (req).
module cdc_ack_sync
    import cdc_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic sync_out
);

    generate
        if (STAGES < CDC_SYNC_STAGES_MIN || STAGES > CDC_SYNC_STAGES_MAX) begin : g_bad_stages
            $error("cdc_ack_sync: STAGES out of range 2..6");
        end
    endgenerate

    // Keep the chain together, away from shift-register packing, so the
    // placer treats it as a metastability-settling path.
    (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking keeps every stage sampling its predecessor's
            // pre-edge value; blocking would collapse the chain to one flop.
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule : cdc_ack_sync

// File: rtl/cdc_handshake_tx.sv
// Source half of a four-phase req/ack CDC bus transfer.
// Optional ack-wait watchdog is built when CDC_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ack,
    output logic             tx_done,
    output logic             timeout
);

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("cdc_handshake_tx: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    cdc_tx_state_t state;
    cdc_tx_state_t next_state;
    logic          ack_s;
    logic          accept;

    cdc_ack_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (tx_ack),
        .sync_out (ack_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: the default assignment up front means every path drives
        // next_state, so no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = REQ;
            REQ:     if (ack_s)  next_state = REL;
            REL:     if (!ack_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A stale-high ack after reset or a spurious ack in IDLE blocks acceptance.
    always_comb begin
        s_ready = (state == IDLE) && !ack_s;
        accept  = s_valid && s_ready;
    end

    // tx_req comes straight from a flop so the destination never sees a
    // decode glitch while the state bits change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_req  <= 1'b0;
            tx_done <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_req  <= (next_state == REQ);
            tx_done <= (state == REL) && !ack_s;
            if (accept) begin
                tx_data <= s_data;
            end
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic             waiting;

    // Counts cycles spent in the current REQ or REL visit; never aborts.
    assign waiting = (state != IDLE) && (next_state == state);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (waiting && wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (waiting && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule : cdc_handshake_tx

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: reset, single and streamed transfers,
// stale ack, mid-transfer reset and the ack-wait watchdog.
module tb_cdc_handshake_tx;

    localparam int WIDTH   = 32;
    localparam int SYNC    = 3;
    localparam int TIMEOUT = 8;
`ifdef CDC_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             tx_req;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ack;
    logic             tx_done;
    logic             timeout;

    logic             ack_auto   = 1'b1;
    logic             ack_manual = 1'b0;
    logic [1:0]       echo_pipe  = 2'b00;
    logic [WIDTH-1:0] cap_q[$];
    int               done_cnt   = 0;
    int               total      = 0;
    int               bad        = 0;

    cdc_handshake_tx #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx_ack  (tx_ack),
        .tx_done (tx_done),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Destination model: echoes tx_req two clocks later and captures the word
    // on the first edge it sees a new request.
    always @(posedge clk) begin
        if (ack_auto && tx_req && !echo_pipe[0]) cap_q.push_back(tx_data);
        echo_pipe <= {echo_pipe[0], tx_req};
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    assign tx_ack = ack_auto ? echo_pipe[1] : ack_manual;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            seen = tx_done;
        end
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) tick();
        total++; if (tx_req !== 1'b0)  begin bad++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
        total++; if (tx_data !== '0)   begin bad++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_single();
        int  base_done;
        int  fall_c = -1;
        int  done_c = -1;
        bit  held   = 1'b1;
        bit  seen;
        base_done = done_cnt;
        s_data  = 32'hA5A5_0001;
        s_valid = 1'b1;
        tick();
        total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL single_req_rise got=%b exp=1", tx_req); end
        total++; if (tx_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data got=%h exp=a5a50001", tx_data); end
        s_data = 32'hA5A5_0002;
        for (int c = 1; c <= 30 && done_c < 0; c++) begin
            tick();
            if (fall_c < 0 && tx_req === 1'b0) fall_c = c;
            if (tx_data !== 32'hA5A5_0001) held = 1'b0;
            if (tx_done === 1'b1) done_c = c;
        end
        total++; if (fall_c != 6)  begin bad++; $display("FAIL single_req_fall_cycle got=%0d exp=6", fall_c); end
        total++; if (done_c != 12) begin bad++; $display("FAIL single_done_cycle got=%0d exp=12", done_c); end
        total++; if (!held) begin bad++; $display("FAIL single_data_held got=changed exp=a5a50001"); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready_at_done got=%b exp=1", s_ready); end
        tick();
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL single_done_width got=%b exp=0", tx_done); end
        total++; if (tx_req !== 1'b1 || tx_data !== 32'hA5A5_0002)
            begin bad++; $display("FAIL single_second_accept got=%b/%h exp=1/a5a50002", tx_req, tx_data); end
        s_valid = 1'b0;
        wait_done(40, seen);
        total++; if (!seen) begin bad++; $display("FAIL single_second_done got=timeout exp=pulse"); end
        tick();
        total++; if (done_cnt - base_done != 2) begin bad++; $display("FAIL single_done_count got=%0d exp=2", done_cnt - base_done); end
        total++; if (cap_q.size() < 2 || cap_q[cap_q.size()-2] !== 32'hA5A5_0001 || cap_q[cap_q.size()-1] !== 32'hA5A5_0002)
            begin bad++; $display("FAIL single_capture got=size%0d exp=a5a50001,a5a50002", cap_q.size()); end
    endtask

    task automatic test_back_to_back();
        int base_done = done_cnt;
        int base_cap  = cap_q.size();
        int n;
        bit ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data  = WIDTH'(i);
            s_valid = 1'b1;
            n = 0;
            while (!s_ready && n < 100) begin tick(); n++; end
            if (n == 100) begin bad++; total++; $display("FAIL b2b_stall got=word%0d exp=accepted", i); end
            tick();
        end
        s_valid = 1'b0;
        n = 0;
        while (done_cnt - base_done < 16 && n < 300) begin tick(); n++; end
        tick();
        total++; if (done_cnt - base_done != 16) begin bad++; $display("FAIL b2b_done_count got=%0d exp=16", done_cnt - base_done); end
        total++; if (cap_q.size() - base_cap != 16) begin bad++; $display("FAIL b2b_capture_count got=%0d exp=16", cap_q.size() - base_cap); end
        for (int i = 0; i < 16 && base_cap + i < cap_q.size(); i++)
            if (cap_q[base_cap+i] !== WIDTH'(i)) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL b2b_order got=out_of_order exp=0..15"); end
    endtask

    // Stale ack through reset release, with upstream valid ignored meanwhile.
    task automatic test_stale_ack();
        bit req_seen = 1'b0;
        bit ready_seen = 1'b0;
        ack_auto   = 1'b0;
        ack_manual = 1'b1;
        resetn     = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        resetn = 1'b1;
        repeat (SYNC + 2) tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL stale_ready got=%b exp=0", s_ready); end
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 32'hDEAD_0000 + WIDTH'(i);
            tick();
            if (tx_req !== 1'b0)  req_seen = 1'b1;
            if (s_ready !== 1'b0) ready_seen = 1'b1;
        end
        s_valid = 1'b0;
        total++; if (req_seen)   begin bad++; $display("FAIL stale_no_req got=req exp=none"); end
        total++; if (ready_seen) begin bad++; $display("FAIL stale_ready_hold got=1 exp=0"); end
        total++; if (tx_data !== '0) begin bad++; $display("FAIL ignored_valid_data got=%h exp=0", tx_data); end
        ack_manual = 1'b0;
        for (int i = 1; i <= SYNC; i++) begin
            tick();
            total++;
            if (s_ready !== (i == SYNC)) begin bad++; $display("FAIL stale_release_c%0d got=%b exp=%b", i, s_ready, i == SYNC); end
        end
        ack_auto = 1'b1;
    endtask

    task automatic test_mid_reset();
        bit seen;
        s_data  = 32'h1234_5678;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL midrst_in_req got=%b exp=1", tx_req); end
        tick();
        resetn = 1'b0;
        #1;
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL midrst_req_async got=%b exp=0", tx_req); end
        total++; if (tx_data !== '0)  begin bad++; $display("FAIL midrst_data_async got=%h exp=0", tx_data); end
        repeat (4) tick();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after got=%b exp=1", s_ready); end
        s_data  = 32'hCAFE_F00D;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        wait_done(40, seen);
        total++; if (!seen) begin bad++; $display("FAIL midrst_next_done got=timeout exp=pulse"); end
        total++; if (cap_q.size() == 0 || cap_q[cap_q.size()-1] !== 32'hCAFE_F00D)
            begin bad++; $display("FAIL midrst_next_capture got=%h exp=cafef00d", cap_q.size() ? cap_q[cap_q.size()-1] : '0); end
    endtask

    task automatic test_timeout();
        bit seen;
        int n = 0;
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        s_data  = 32'h0BAD_0ACE;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 7 || j == 8 || j == 12) begin
                total++;
                if (timeout !== (TO_EN && j >= TIMEOUT))
                    begin bad++; $display("FAIL timeout_c%0d got=%b exp=%b", j, timeout, TO_EN && j >= TIMEOUT); end
            end
        end
        total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL timeout_no_abort got=%b exp=1", tx_req); end
        ack_manual = 1'b1;
        while (tx_req !== 1'b0 && n < 20) begin tick(); n++; end
        ack_manual = 1'b0;
        wait_done(20, seen);
        total++; if (!seen) begin bad++; $display("FAIL timeout_complete got=timeout exp=pulse"); end
        total++; if (timeout !== TO_EN) begin bad++; $display("FAIL timeout_sticky got=%b exp=%b", timeout, TO_EN); end
        ack_auto = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stale_ack();
        test_mid_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cdc_handshake_tx
